// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared data memory.
// Port 0 (instruction fetch) only reads; port 1 (load/store) reads or writes.
// Each transaction is IDLE -> ISSUE -> RESP: the memory controls are high for
// the ISSUE cycle only, and the ack pulses for the RESP cycle.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0Req,
  input  logic [17:0] p0Addr,
  output logic        p0Ack,
  output logic [31:0] p0Rdata,
  input  logic        p1Req,
  input  logic        p1We,
  input  logic [17:0] p1Addr,
  input  logic [31:0] p1Wdata,
  output logic        p1Ack,
  output logic [31:0] p1Rdata,
  output logic        memRead,
  output logic        memWrite,
  output logic [17:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        grant_id_q, grant_id_d;
  logic        last_grant_q, last_grant_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [17:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        p0_ack_q, p0_ack_d;
  logic        p1_ack_q, p1_ack_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;

  // Winner when at least one port requests: on a tie, the port not served last.
  logic win_id;
  assign win_id = (p0Req && p1Req) ? ~last_grant_q : p1Req;

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;

    case (state_q)
      StIdle: begin
        if (p0Req || p1Req) begin
          grant_id_d = win_id;
          state_d    = StIssue;
          if (win_id) begin
            address_d   = p1Addr;
            mem_read_d  = ~p1We;
            mem_write_d = p1We;
            if (p1We) begin
              write_data_d = p1Wdata;
            end
          end else begin
            address_d   = p0Addr;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
          end
        end
      end
      StIssue: begin
        // The memory acted on the negedge inside ISSUE, so read_data is settled.
        state_d     = StResp;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (grant_id_q) begin
          p1_ack_d = 1'b1;
          if (mem_read_q) begin
            p1_rdata_d = read_data;
          end
        end else begin
          p0_ack_d = 1'b1;
          if (mem_read_q) begin
            p0_rdata_d = read_data;
          end
        end
      end
      StResp: begin
        last_grant_d = grant_id_q;
        state_d      = StIdle;
      end
      default: begin
        state_d     = StIdle;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign memRead    = mem_read_q;
  assign memWrite   = mem_write_q;
  assign address    = address_q;
  assign write_data = write_data_q;
  assign p0Ack      = p0_ack_q;
  assign p1Ack      = p1_ack_q;
  assign p0Rdata    = p0_rdata_q;
  assign p1Rdata    = p1_rdata_q;
  assign busy       = (state_q != StIdle);

endmodule
